inverse_matrix_ctrl: RTL and testbench

Sequencing controller for the 2x2 matrix-inverse datapath. On `start` it reads four signed matrix elements from the random-access memory and computes the determinant. It then issues four Q16.16 divisions to the shared external divider through a req/ack handshake, and writes the determinant and the inverse back to the same memory. It sits between the `inverse_matrix` top level, the memory and the divider, and reports progress on a 32-bit `wr_st` status word.

---
 rtl/inverse_matrix_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_inverse_matrix_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_matrix_ctrl.sv
// inverse_matrix_ctrl: sequencer for the 2x2 matrix-inverse datapath.
// Reads a, b, c, d from memory, computes det = a*d - b*c, writes det,
// then runs four Q16.16 divisions (adj/det) on an external req/ack divider
// and writes the inverse back to memory.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 level request, sampled in IDLE
//   mem_addr/_rd_en/_rdata/_wr_en/_wdata  memory port (1-cycle read latency)
//   div_req/_num/_den/_ack/_quo           divider handshake
//   done                  one-cycle completion pulse
//   wr_st                 status: [31:28] state, [27:24] written count,
//                         [2] range error, [1] singular, [0] busy
module inverse_matrix_ctrl #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned BASE_IN  = 0,
  parameter int unsigned BASE_OUT = 4,
  parameter int unsigned DET_ADDR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              div_req,
  output logic [31:0]       div_num,
  output logic [31:0]       div_den,
  input  logic              div_ack,
  input  logic [31:0]       div_quo,
  output logic              done,
  output logic [31:0]       wr_st
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_DET  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_WDET = 3'd4;
  localparam logic [2:0] S_DIV  = 3'd5;
  localparam logic [2:0] S_WR   = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic signed [15:0] ELEM_MIN = 16'sh8000;

  logic [2:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic signed [15:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic signed [31:0] det_q, det_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               range_q, range_d;
  logic               sing_q, sing_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               req_q, req_d;
  logic [31:0]        num_q, num_d;
  logic [31:0]        den_q, den_d;
  logic               done_q, done_d;

  logic signed [31:0] prod_ad, prod_bc;
  logic [1:0]         adj_k;
  logic [15:0]        adj_v;
  logic               unused_rdata_hi;

  // Only the low half of a memory word carries the element.
  assign unused_rdata_hi = ^mem_rdata[31:16];

  // Range exclusion of 0x8000 keeps both products and their difference in 32 bits.
  assign prod_ad = 32'(a_q) * 32'(d_q);
  assign prod_bc = 32'(b_q) * 32'(c_q);

  // Adjugate element for the division being launched: 0 from WDET, k+1 from WR.
  always_comb begin
    adj_k = 2'd0;
    if (state_q == S_WR) adj_k = cnt_q[1:0] + 2'd1;
  end

  always_comb begin
    adj_v = d_q;
    unique case (adj_k)
      2'd0:    adj_v = d_q;
      2'd1:    adj_v = -b_q;
      2'd2:    adj_v = -c_q;
      default: adj_v = a_q;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    det_d   = det_q;
    wcnt_d  = wcnt_q;
    range_d = range_q;
    sing_d  = sing_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    wdata_d = wdata_q;
    req_d   = req_q;
    num_d   = num_q;
    den_d   = den_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          cnt_d   = 3'd0;
          range_d = 1'b0;
          sing_d  = 1'b0;
          wcnt_d  = 4'd0;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          addr_d  = ADDR_W'(BASE_IN);
        end
      end

      // cnt_q = number of reads already issued; data for read n-1 is on mem_rdata.
      S_RD: begin
        case (cnt_q)
          3'd1:    a_d = mem_rdata[15:0];
          3'd2:    b_d = mem_rdata[15:0];
          3'd3:    c_d = mem_rdata[15:0];
          3'd4:    d_d = mem_rdata[15:0];
          default: ;
        endcase
        if (cnt_q < 3'd3) begin
          rd_en_d = 1'b1;
          addr_d  = ADDR_W'(BASE_IN + 32'(cnt_q) + 32'd1);
        end
        if (cnt_q == 3'd4) begin
          state_d = S_DET;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_DET: begin
        det_d   = prod_ad - prod_bc;
        state_d = S_CHK;
      end

      S_CHK: begin
        if ((a_q == ELEM_MIN) || (b_q == ELEM_MIN) ||
            (c_q == ELEM_MIN) || (d_q == ELEM_MIN)) begin
          range_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = ADDR_W'(DET_ADDR);
          wdata_d = det_q;
          state_d = S_WDET;
        end
      end

      S_WDET: begin
        if (det_q == 32'sd0) begin
          sing_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = 3'd0;
          req_d   = 1'b1;
          num_d   = {adj_v, 16'h0000};
          den_d   = det_q;
          state_d = S_DIV;
        end
      end

      // Operands hold in their registers for the whole request.
      S_DIV: begin
        if (div_ack && req_q) begin
          req_d   = 1'b0;
          wr_en_d = 1'b1;
          addr_d  = ADDR_W'(BASE_OUT + 32'(cnt_q));
          wdata_d = div_quo;
          wcnt_d  = wcnt_q + 4'd1;
          state_d = S_WR;
        end
      end

      S_WR: begin
        if (cnt_q < 3'd3) begin
          cnt_d   = cnt_q + 3'd1;
          req_d   = 1'b1;
          num_d   = {adj_v, 16'h0000};
          state_d = S_DIV;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      det_q   <= '0;
      wcnt_q  <= '0;
      range_q <= 1'b0;
      sing_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      num_q   <= '0;
      den_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      det_q   <= det_d;
      wcnt_q  <= wcnt_d;
      range_q <= range_d;
      sing_q  <= sing_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      num_q   <= num_d;
      den_q   <= den_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_wdata = wdata_q;
  assign div_req   = req_q;
  assign div_num   = num_q;
  assign div_den   = den_q;
  assign done      = done_q;
  assign wr_st     = {1'b0, state_q, wcnt_q, 21'd0, range_q, sing_q, busy_q};

endmodule

// File: tb/tb_inverse_matrix_ctrl.sv
// Directed bench for inverse_matrix_ctrl with memory and divider models and
// a write scoreboard (expected memory writes queued before each operation).
module tb_inverse_matrix_ctrl;

  localparam int unsigned ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic              div_req;
  logic [31:0]       div_num;
  logic [31:0]       div_den;
  logic              div_ack;
  logic [31:0]       div_quo;
  logic              done;
  logic [31:0]       wr_st;

  int n_cmp = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_req = 0;
  int n_done = 0;

  wr_t         exp_q[$];
  logic [31:0] mem[16];
  logic [31:0] init_mem[16];
  logic        load = 1'b0;
  int          lat_tab[4];
  logic        spur_en = 1'b0;

  inverse_matrix_ctrl #(
    .ADDR_W(4), .BASE_IN(0), .BASE_OUT(4), .DET_ADDR(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .div_req(div_req), .div_num(div_num), .div_den(div_den),
    .div_ack(div_ack), .div_quo(div_quo),
    .done(done), .wr_st(wr_st)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (load) mem <= init_mem;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Divider model: ack lat_tab[k] cycles after req rises, operands captured at rise.
  initial begin : divider
    int cnt;
    int lat;
    logic busy;
    logic [31:0] num, den;
    div_ack = 1'b0; div_quo = '0;
    cnt = 0; lat = 1; busy = 1'b0; num = '0; den = '0;
    forever begin
      @(posedge clk); #1;
      div_ack = 1'b0;
      if (busy) begin
        cnt++;
        if (div_req === 1'b1) begin
          check("div_num_stable", div_num, num);
          check("div_den_stable", div_den, den);
        end
        if (cnt == lat) begin
          busy    = 1'b0;
          div_ack = 1'b1;
          div_quo = 32'($signed(num) / $signed(den));
        end
      end else if (div_req === 1'b1) begin
        busy = 1'b1;
        cnt  = 0;
        num  = div_num;
        den  = div_den;
        lat  = lat_tab[wr_st[25:24]];
      end else if (spur_en && wr_st[31:28] == 4'd6) begin
        div_ack = 1'b1;
        div_quo = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: scoreboard on writes, enable exclusivity, event counters.
  initial begin : monitor
    wr_t  e;
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_en === 1'b1 || mem_wr_en === 1'b1)
        check("rd_wr_exclusive", 32'(mem_rd_en & mem_wr_en), 32'd0);
      if (mem_wr_en === 1'b1) begin
        n_wr++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_unexpected_write: observed addr %0d data 0x%08h, expected no write",
                 mem_addr, mem_wdata);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", mem_wdata, e.data);
        end
      end
      if (div_req === 1'b1 && !req_prev) n_req++;
      req_prev = div_req;
      if (done === 1'b1) n_done++;
    end
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic [15:0] hi);
    for (int i = 0; i < 16; i++) init_mem[i] = 32'hCAFE_0000 | 32'(i);
    init_mem[0] = {hi, a};
    init_mem[1] = {hi, b};
    init_mem[2] = {hi, c};
    init_mem[3] = {hi, d};
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic push(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_inv(input logic [31:0] det, input logic [31:0] i00, input logic [31:0] i01,
                          input logic [31:0] i10, input logic [31:0] i11);
    push(4'd8, det);
    push(4'd4, i00);
    push(4'd5, i01);
    push(4'd6, i10);
    push(4'd7, i11);
  endtask

  // Raise start, expect first read strobe one cycle later, then count cycles to done.
  task automatic run_op(input string tag, input int exp_cyc, input bit hold);
    int dly;
    int cyc;
    start = 1'b1;
    dly = 0;
    while (mem_rd_en !== 1'b1 && dly < 4) begin @(negedge clk); dly++; end
    check({tag, "_strobe_delay"}, 32'(dly), 32'd1);
    if (!hold) start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic check_inv(input string tag, input logic [31:0] det, input logic [31:0] i00,
                           input logic [31:0] i01, input logic [31:0] i10, input logic [31:0] i11);
    check({tag, "_mem8"}, mem[8], det);
    check({tag, "_mem4"}, mem[4], i00);
    check({tag, "_mem5"}, mem[5], i01);
    check({tag, "_mem6"}, mem[6], i10);
    check({tag, "_mem7"}, mem[7], i11);
  endtask

  initial begin : main
    int w0, r0, d0, wait_cnt;
    rst_n = 1'b1; start = 1'b0;
    lat_tab = '{3, 3, 3, 3};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_st", wr_st, 32'd0);
    check("rst_strobes", 32'({mem_rd_en, mem_wr_en, div_req, done}), 32'd0);
    rst_n = 1'b1;

    // Normal inverse, L=3.
    preload(16'd4, 16'd7, 16'd2, 16'd6, 16'h0000);
    push_inv(32'd10, 32'h0000_9999, 32'hFFFF_4CCD, 32'hFFFF_CCCD, 32'h0000_6666);
    d0 = n_done;
    run_op("normal", 28, 1'b0);
    check("normal_st_done", wr_st, 32'h7400_0000);
    @(negedge clk);
    check("normal_done_pulse", 32'(done), 32'd0);
    check("normal_st_idle", wr_st, 32'h0400_0000);
    check("normal_done_count", 32'(n_done - d0), 32'd1);
    check_inv("normal", 32'd10, 32'h0000_9999, 32'hFFFF_4CCD, 32'hFFFF_CCCD, 32'h0000_6666);
    check("normal_sb_empty", 32'(exp_q.size()), 32'd0);

    // Singular: junk in upper halves must be ignored.
    preload(16'd1, 16'd2, 16'd2, 16'd4, 16'hBEEF);
    push(4'd8, 32'd0);
    r0 = n_req;
    run_op("singular", 8, 1'b0);
    check("singular_st", wr_st, 32'h7000_0002);
    @(negedge clk);
    check("singular_no_req", 32'(n_req - r0), 32'd0);
    check("singular_mem8", mem[8], 32'd0);
    check("singular_mem4", mem[4], 32'hCAFE_0004);
    check("singular_mem7", mem[7], 32'hCAFE_0007);
    check("singular_sb_empty", 32'(exp_q.size()), 32'd0);

    // Range error on element b.
    preload(16'd3, 16'h8000, 16'd5, 16'd6, 16'h0000);
    w0 = n_wr; r0 = n_req;
    run_op("range", 7, 1'b0);
    check("range_st", wr_st, 32'h7000_0004);
    @(negedge clk);
    check("range_no_writes", 32'(n_wr - w0), 32'd0);
    check("range_no_req", 32'(n_req - r0), 32'd0);
    check("range_mem8", mem[8], 32'hCAFE_0008);

    // Handshake stall on the 2nd division, spurious acks in WR.
    preload(16'd4, 16'd7, 16'd2, 16'd6, 16'h0000);
    lat_tab = '{3, 20, 3, 3};
    spur_en = 1'b1;
    push_inv(32'd10, 32'h0000_9999, 32'hFFFF_4CCD, 32'hFFFF_CCCD, 32'h0000_6666);
    run_op("stall", 45, 1'b0);
    check("stall_st", wr_st, 32'h7400_0000);
    @(negedge clk);
    spur_en = 1'b0;
    lat_tab = '{3, 3, 3, 3};
    check_inv("stall", 32'd10, 32'h0000_9999, 32'hFFFF_4CCD, 32'hFFFF_CCCD, 32'h0000_6666);

    // Reset during the 3rd request; the late ack must be ignored.
    preload(16'd4, 16'd7, 16'd2, 16'd6, 16'h0000);
    lat_tab = '{3, 3, 8, 3};
    push(4'd8, 32'd10);
    push(4'd4, 32'h0000_9999);
    push(4'd5, 32'hFFFF_4CCD);
    w0 = n_wr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cnt = 0;
    while (!(div_req === 1'b1 && wr_st[27:24] == 4'd2) && wait_cnt < 100) begin
      @(negedge clk); wait_cnt++;
    end
    check("rstdiv_reached_3rd_req", 32'(div_req), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstdiv_wr_st", wr_st, 32'd0);
    check("rstdiv_strobes", 32'({mem_rd_en, mem_wr_en, div_req, done}), 32'd0);
    check("rstdiv_div_num", div_num, 32'd0);
    check("rstdiv_div_den", div_den, 32'd0);
    check("rstdiv_mem_addr", 32'(mem_addr), 32'd0);
    check("rstdiv_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rstdiv_idle_after_ack", wr_st, 32'd0);
    check("rstdiv_writes", 32'(n_wr - w0), 32'd3);
    check("rstdiv_sb_empty", 32'(exp_q.size()), 32'd0);
    lat_tab = '{3, 3, 3, 3};
    preload(16'd1, 16'd2, 16'd3, 16'd4, 16'h0000);
    push_inv(32'hFFFF_FFFE, 32'hFFFE_0000, 32'h0001_0000, 32'h0001_8000, 32'hFFFF_8000);
    run_op("restart", 28, 1'b0);
    @(negedge clk);
    check_inv("restart", 32'hFFFF_FFFE, 32'hFFFE_0000, 32'h0001_0000, 32'h0001_8000, 32'hFFFF_8000);

    // Back-to-back with start held high, negative determinant.
    preload(16'd1, 16'd2, 16'd3, 16'd4, 16'h0000);
    push_inv(32'hFFFF_FFFE, 32'hFFFE_0000, 32'h0001_0000, 32'h0001_8000, 32'hFFFF_8000);
    push_inv(32'hFFFF_FFFE, 32'hFFFE_0000, 32'h0001_0000, 32'h0001_8000, 32'hFFFF_8000);
    d0 = n_done;
    run_op("b2b_first", 28, 1'b1);
    @(negedge clk);
    check("b2b_idle_after_done", 32'(wr_st[31:28]), 32'd0);
    @(negedge clk);
    check("b2b_restart_strobe", 32'(mem_rd_en), 32'd1);
    start = 1'b0;
    wait_cnt = 0;
    while (done !== 1'b1 && wait_cnt < 300) begin @(negedge clk); wait_cnt++; end
    check("b2b_second_cycles", 32'(wait_cnt), 32'd28);
    check("b2b_st", wr_st, 32'h7400_0000);
    @(negedge clk);
    check("b2b_done_count", 32'(n_done - d0), 32'd2);
    check_inv("b2b", 32'hFFFF_FFFE, 32'hFFFE_0000, 32'h0001_0000, 32'h0001_8000, 32'hFFFF_8000);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
